// File: rtl/voice_allocator_pkg.sv
// rtl/voice_allocator_pkg.sv - shared pipeline-pool types and widths for the voice allocator
package voice_allocator_pkg;

  localparam int PIPELINE_COUNT  = 4;
  localparam int PERCENT_WIDTH   = 7;
  localparam int NOTE_WIDTH      = 7;
  localparam int VOICE_AGE_WIDTH = $clog2(PIPELINE_COUNT);

  typedef logic [PERCENT_WIDTH-1:0] percent_t;
  typedef logic [NOTE_WIDTH-1:0]    note_t;

  typedef struct packed {
    logic     active;
    note_t    note;
    percent_t velocity;
  } voice_config_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } alloc_state_t;

endpackage

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - assigns note-on/off events to pipelines, stealing the oldest voice when full
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int VOICES     = voice_allocator_pkg::PIPELINE_COUNT,
  parameter int NOTE_WIDTH = voice_allocator_pkg::NOTE_WIDTH
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    event_valid,
  output logic                                    event_ready,
  input  logic                                    event_on,
  input  logic [NOTE_WIDTH-1:0]                   event_note,
  input  logic [PERCENT_WIDTH-1:0]                event_velocity,
  output logic [VOICES-1:0]                       voice_active,
  output logic [VOICES-1:0][NOTE_WIDTH-1:0]       voice_note,
  output logic [VOICES-1:0][PERCENT_WIDTH-1:0]    voice_velocity,
  output logic [VOICES-1:0]                       voice_start,
  output logic [VOICES-1:0]                       voice_release
);

  // Index and age share one width: ages saturate at VOICES-1.
  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(VOICES - 1);

  alloc_state_t            state;
  logic [IW-1:0]           scan_idx;
  logic                    ev_on;
  logic [NOTE_WIDTH-1:0]   ev_note;
  logic [PERCENT_WIDTH-1:0] ev_vel;
  logic                    match_found, free_found, old_found;
  logic [IW-1:0]           match_idx, free_idx, old_idx, old_age;
  logic [IW-1:0]           age [VOICES];
  logic [IW-1:0]           target;

  always_comb begin
    target = old_idx;
    if (match_found)     target = match_idx;
    else if (free_found) target = free_idx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      event_ready    <= 1'b0;
      scan_idx       <= '0;
      ev_on          <= 1'b0;
      ev_note        <= '0;
      ev_vel         <= '0;
      match_found    <= 1'b0;
      free_found     <= 1'b0;
      old_found      <= 1'b0;
      match_idx      <= '0;
      free_idx       <= '0;
      old_idx        <= '0;
      old_age        <= '0;
      voice_active   <= '0;
      voice_note     <= '0;
      voice_velocity <= '0;
      voice_start    <= '0;
      voice_release  <= '0;
      for (int i = 0; i < VOICES; i++) age[i] <= '0;
    end else begin
      voice_start   <= '0;
      voice_release <= '0;
      case (state)
        ST_IDLE: begin
          event_ready <= 1'b1;
          if (event_valid && event_ready) begin
            // Velocity-0 note-on is a note-off.
            ev_on       <= event_on && (event_velocity != '0);
            ev_note     <= event_note;
            ev_vel      <= event_velocity;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            event_ready <= 1'b0;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (voice_active[scan_idx]) begin
            if (!match_found && voice_note[scan_idx] == ev_note) begin
              match_found <= 1'b1;
              match_idx   <= scan_idx;
            end
            if (!old_found || age[scan_idx] > old_age) begin
              old_found <= 1'b1;
              old_idx   <= scan_idx;
              old_age   <= age[scan_idx];
            end
          end else if (!free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (scan_idx == LAST_IDX) state    <= ST_COMMIT;
          else                      scan_idx <= scan_idx + IW'(1);
        end
        ST_COMMIT: begin
          if (ev_on) begin
            for (int i = 0; i < VOICES; i++) begin
              if (target == IW'(i)) begin
                voice_active[i]   <= 1'b1;
                voice_note[i]     <= ev_note;
                voice_velocity[i] <= ev_vel;
                voice_start[i]    <= 1'b1;
                age[i]            <= '0;
              end else if (voice_active[i] && age[i] != LAST_IDX) begin
                age[i] <= age[i] + IW'(1);
              end
            end
          end else if (match_found) begin
            voice_active[match_idx]  <= 1'b0;
            voice_release[match_idx] <= 1'b1;
          end
          event_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - randomized check of voice_allocator against a behavioural voice-pool model
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int V = PIPELINE_COUNT;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          event_valid;
  logic                          event_ready;
  logic                          event_on;
  logic [6:0]                    event_note;
  logic [PERCENT_WIDTH-1:0]      event_velocity;
  logic [V-1:0]                  voice_active;
  logic [V-1:0][6:0]             voice_note;
  logic [V-1:0][PERCENT_WIDTH-1:0] voice_velocity;
  logic [V-1:0]                  voice_start;
  logic [V-1:0]                  voice_release;

  int errors = 0;
  int checks = 0;

  bit m_active [V];
  int m_note   [V];
  int m_vel    [V];
  int m_age    [V];

  voice_allocator dut (
    .clock(clock), .reset(reset),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_on(event_on), .event_note(event_note), .event_velocity(event_velocity),
    .voice_active(voice_active), .voice_note(voice_note), .voice_velocity(voice_velocity),
    .voice_start(voice_start), .voice_release(voice_release)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < V; i++) begin
      m_active[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
  endtask

  // Pool rules: reuse same note, else lowest free voice, else steal the eldest.
  task automatic model_apply(input bit on, input int n, input int v,
                             output logic [V-1:0] s, output logic [V-1:0] r);
    int m, f, o, t;
    s = '0; r = '0; m = -1; f = -1; o = -1;
    for (int i = 0; i < V; i++) begin
      if (m < 0 && m_active[i] && m_note[i] == n) m = i;
      if (f < 0 && !m_active[i]) f = i;
      if (m_active[i] && (o < 0 || m_age[i] > m_age[o])) o = i;
    end
    if (on && v != 0) begin
      t = (m >= 0) ? m : ((f >= 0) ? f : o);
      for (int i = 0; i < V; i++)
        if (i != t && m_active[i]) m_age[i] = (m_age[i] + 1 > V - 1) ? V - 1 : m_age[i] + 1;
      m_active[t] = 1; m_note[t] = n; m_vel[t] = v; m_age[t] = 0;
      s[t] = 1'b1;
    end else if (m >= 0) begin
      m_active[m] = 0;
      r[m] = 1'b1;
    end
  endtask

  task automatic compare_voices();
    for (int i = 0; i < V; i++) begin
      check($sformatf("active%0d", i), voice_active[i], m_active[i]);
      check($sformatf("note%0d", i), voice_note[i], m_note[i]);
      check($sformatf("vel%0d", i), voice_velocity[i], m_vel[i]);
    end
  endtask

  task automatic send_event(input bit on, input int n, input int v);
    logic [V-1:0] es, er, stray;
    int waits;
    model_apply(on, n, v, es, er);
    waits = 0;
    while (!event_ready && waits < 20) begin @(negedge clock); waits++; end
    check("ready_before", event_ready, 1);
    event_valid = 1'b1; event_on = on; event_note = 7'(n); event_velocity = 7'(v);
    @(posedge clock); #1;
    event_valid = 1'b0;
    event_on = 1'($urandom); event_note = 7'($urandom); event_velocity = 7'($urandom);
    @(negedge clock);
    waits = 0; stray = '0;
    while (!event_ready && waits < 20) begin
      stray |= voice_start | voice_release;
      waits++;
      @(negedge clock);
    end
    check("ready_low_cycles", waits, V + 1);
    check("early_pulse", stray, 0);
    check("start_pulse", voice_start, es);
    check("release_pulse", voice_release, er);
    compare_voices();
    @(negedge clock);
    check("start_cleared", voice_start, 0);
    check("release_cleared", voice_release, 0);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("ready_after_reset", event_ready, 1);
    @(negedge clock);
    model_clear();
  endtask

  initial begin
    reset = 1'b1; event_valid = 1'b0; event_on = 1'b0; event_note = '0; event_velocity = '0;
    model_clear();
    @(negedge clock); @(negedge clock);
    check("rst_ready", event_ready, 0);
    check("rst_active", voice_active, 0);
    check("rst_start", voice_start, 0);
    check("rst_release", voice_release, 0);
    compare_voices();
    reset = 1'b0;
    #1 check("ready_low_until_edge", event_ready, 0);
    @(posedge clock); #1 check("ready_first_edge", event_ready, 1);
    @(negedge clock);

    send_event(1, 60, 100);

    do_reset();
    send_event(1, 60, 100); send_event(1, 62, 100); send_event(1, 64, 100);
    send_event(1, 67, 100); send_event(1, 72, 90);
    check("steal_note0", voice_note[0], 72);

    do_reset();
    send_event(1, 60, 100); send_event(1, 60, 50);
    check("retrig_vel0", voice_velocity[0], 50);

    do_reset();
    send_event(1, 60, 100); send_event(0, 60, 0); send_event(0, 61, 0);
    check("off_keeps_note", voice_note[0], 60);

    do_reset();
    send_event(1, 64, 100); send_event(1, 64, 0);

    do_reset();
    send_event(1, 50, 90);
    while (!event_ready) @(negedge clock);
    event_valid = 1'b1; event_on = 1'b1; event_note = 7'd52; event_velocity = 7'd80;
    @(posedge clock); #1 event_valid = 1'b0;
    @(posedge clock); #2 reset = 1'b1;
    #1;
    check("midscan_active", voice_active, 0);
    check("midscan_note0", voice_note[0], 0);
    check("midscan_ready", event_ready, 0);
    check("midscan_start", voice_start, 0);
    @(negedge clock); @(negedge clock); reset = 1'b0;
    #1 check("midscan_ready_held", event_ready, 0);
    @(posedge clock); #1 check("midscan_ready_up", event_ready, 1);
    for (int k = 0; k < V + 2; k++) begin
      @(negedge clock);
      check("midscan_no_pulse", voice_start | voice_release, 0);
    end
    model_clear();
    compare_voices();

    for (int k = 0; k < 150; k++) begin
      send_event($urandom_range(0, 3) != 0, 60 + $urandom_range(0, 7),
                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Assigns incoming note-on/note-off events to the `CONFIG::PIPELINE_COUNT` synthesis pipelines and holds each pipeline's note/velocity configuration. It sits between the MIDI decoder and the per-voice audio pipelines. It is the arbiter for the shared pipeline pool:
- finds a free voice for each new note;
- steals the oldest voice when all are busy;
- releases the matching voice on note-off.

## Interface
Parameters:
- `VOICES`, default `CONFIG::PIPELINE_COUNT` (4): number of managed pipelines.
- `NOTE_WIDTH`, default 7: MIDI note number width.

Ports:
- `clock`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `event_valid`  in  1  event present.
- `event_ready`  out  1  allocator accepts an event this cycle.
- `event_on`  in  1  1 = note-on, 0 = note-off.
- `event_note`  in  `NOTE_WIDTH`  note number.
- `event_velocity`  in  `CONFIG::PERCENT_WIDTH`  velocity, 0..127.
- `voice_active`  out  `VOICES`  voice is sounding (gate).
- `voice_note`  out  `VOICES` x `NOTE_WIDTH`  note per voice.
- `voice_velocity`  out  `VOICES` x `PERCENT_WIDTH`  velocity per voice.
- `voice_start`  out  `VOICES`  one-cycle pulse: voice (re)triggered; pipeline resets phase and envelope.
- `voice_release`  out  `VOICES`  one-cycle pulse: voice entered release.

## Operation
- FSM states: IDLE, SCAN, COMMIT.
- IDLE: `event_ready`=1. When `event_valid && event_ready`, latch the event and go to SCAN with index 0.
- Note-on with velocity 0 is treated as note-off.
- SCAN: examines one voice per cycle, index 0..VOICES-1, and tracks three candidates:
  - match: the lowest-index active voice whose note equals the event note;
  - free: the lowest-index inactive voice;
  - oldest: the active voice with maximum age; ties go to the lowest index.
- After index VOICES-1, go to COMMIT.
- COMMIT, note-on: target is match if one exists, else free, else oldest (steal).
  - Target gets active=1, note and velocity written, age=0, `voice_start` pulse.
  - Every other active voice: age +1, saturating at VOICES-1.
- COMMIT, note-off: if match exists, clear its active bit and pulse `voice_release`; note, velocity and age are retained. With no match the event is dropped silently.
- COMMIT always returns to IDLE.
- Age width: `$clog2(VOICES)`. Ages of inactive voices are not incremented.
- Stolen voice: gets only `voice_start`, no `voice_release`. Its pipeline retriggers in place.

## Timing
- Handshake on edge E0. SCAN occupies edges E1..E_VOICES. COMMIT register update happens on edge E_{VOICES+1}.
- `voice_*` outputs change on E_{VOICES+1}. `voice_start`/`voice_release` are high for exactly the cycle following E_{VOICES+1}.
- `event_ready` is registered and low from E0 through E_{VOICES+1}. It is high again in the cycle after E_{VOICES+1}.
- Throughput: one event per VOICES+2 cycles (6 cycles at VOICES=4, i.e. 120 ns).
- `event_*` inputs are sampled only at the handshake. Changes while `event_ready`=0 are ignored.
- Reset, applied asynchronously:
  - state=IDLE;
  - `event_ready`=0, rising to 1 on the first clock edge after `reset` deasserts;
  - all `voice_active`, `voice_note`, `voice_velocity`, `voice_start`, `voice_release` and ages = 0.
- Reset mid-SCAN/COMMIT discards the in-flight event; no pulses are emitted.

## Structure
Add to `CONFIG`:
- `NOTE_WIDTH` (7);
- `typedef logic [NOTE_WIDTH-1:0] note_t`;
- `VOICE_AGE_WIDTH = $clog2(PIPELINE_COUNT)`;
- `typedef struct packed { logic active; note_t note; percent_t velocity; }` `voice_config_t`, consumed by the pipelines.

The FSM, scan index, candidate registers and per-voice state array live in one module. No sub-module is warranted; the scan compare is inline.

## Test plan
- Reset, then note-on 60/vel 100: voice0 active, note 60, `voice_start`=4'b0001 for 1 cycle. `event_ready` is low exactly 5 cycles after the handshake.
- Note-on 60, 62, 64, 67, then note-on 72: 72 steals voice0, the oldest. `voice_start`=4'b0001, `voice_release` stays 0, voice0 note=72.
- Note-on 60 twice, with vel 100 then vel 50: same voice retriggered. Two `voice_start` pulses on voice0, velocity 50, voices1-3 inactive.
- Note-on 60, then note-off 60: `voice_release`=4'b0001, `voice_active`=0, note remains 60. Then note-off 61: no outputs change, `event_ready` returns after 5 cycles.
- Note-on 64 with vel 0 while 64 is active: behaves as note-off, releasing that voice.
- Assert `reset` during SCAN of a note-on: all outputs 0 immediately, no pulse. `event_ready` is 1 one edge after deassertion.
